// File: rtl/stack_upstream_arbiter.sv
// rtl/stack_upstream_arbiter.sv - packet-atomic round-robin arbiter onto the PE-to-stack upstream bus
// Optional per-requester EOP counters: define STACK_UP_ARB_PKT_STATS_EN.
module stack_upstream_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int CNTL_W  = 2,
    parameter int TYPE_W  = 2,
    parameter int DATA_W  = 64,
    parameter int OOB_W   = 32
) (
    input  logic                      clk,
    input  logic                      reset_poweron,
    input  logic [NUM_REQ-1:0]        req__arb__valid,
    input  logic [NUM_REQ*CNTL_W-1:0] req__arb__cntl,
    input  logic [NUM_REQ*TYPE_W-1:0] req__arb__type,
    input  logic [NUM_REQ*DATA_W-1:0] req__arb__data,
    input  logic [NUM_REQ*OOB_W-1:0]  req__arb__oob_data,
    output logic [NUM_REQ-1:0]        arb__req__ready,
    output logic                      pe__stu__valid,
    output logic [CNTL_W-1:0]         pe__stu__cntl,
    input  logic                      stu__pe__ready,
    output logic [TYPE_W-1:0]         pe__stu__type,
    output logic [DATA_W-1:0]         pe__stu__data,
    output logic [OOB_W-1:0]          pe__stu__oob_data,
    output logic [2:0]                arb__grant_id,
    output logic                      arb__busy,
`ifdef STACK_UP_ARB_PKT_STATS_EN
    output logic [NUM_REQ*16-1:0]     arb__pkt_count,
`endif
    output logic                      arb__proto_err
);

    typedef enum logic {IDLE, PKT} state_t;

    state_t      state;
    logic [2:0]  ptr;
    logic [2:0]  grant;
    logic        first_beat;
    logic        load_ok;
    logic        xfer;

    logic              g_valid;
    logic [CNTL_W-1:0] g_cntl;
    logic [TYPE_W-1:0] g_type;
    logic [DATA_W-1:0] g_data;
    logic [OOB_W-1:0]  g_oob;

    logic        found;
    logic [2:0]  win;
    logic [2:0]  win_next;
    logic        idle_err;

    assign load_ok       = ~pe__stu__valid | stu__pe__ready;
    assign xfer          = (state == PKT) & g_valid & load_ok;
    assign arb__busy     = (state == PKT);
    assign arb__grant_id = grant;
    assign win_next      = (win == 3'(NUM_REQ - 1)) ? 3'd0 : win + 3'd1;

    always_comb begin
        g_valid = 1'b0;
        g_cntl  = '0;
        g_type  = '0;
        g_data  = '0;
        g_oob   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == 3'(i)) begin
                g_valid = req__arb__valid[i];
                g_cntl  = req__arb__cntl[i*CNTL_W +: CNTL_W];
                g_type  = req__arb__type[i*TYPE_W +: TYPE_W];
                g_data  = req__arb__data[i*DATA_W +: DATA_W];
                g_oob   = req__arb__oob_data[i*OOB_W +: OOB_W];
            end
        end
    end

    // Round-robin search starting at ptr; only SOP beats may open a packet.
    always_comb begin
        int idx;
        found    = 1'b0;
        win      = 3'd0;
        idle_err = 1'b0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req__arb__valid[idx] && req__arb__cntl[idx*CNTL_W]) begin
                found = 1'b1;
                win   = 3'(idx);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req__arb__valid[i] && !req__arb__cntl[i*CNTL_W]) idle_err = 1'b1;
        end
    end

    always_comb begin
        arb__req__ready = '0;
        if (state == PKT) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant == 3'(i)) arb__req__ready[i] = load_ok;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state             <= IDLE;
            ptr               <= 3'd0;
            grant             <= 3'd0;
            first_beat        <= 1'b0;
            arb__proto_err    <= 1'b0;
            pe__stu__valid    <= 1'b0;
            pe__stu__cntl     <= '0;
            pe__stu__type     <= '0;
            pe__stu__data     <= '0;
            pe__stu__oob_data <= '0;
        end else begin
            if (xfer) begin
                pe__stu__valid    <= 1'b1;
                pe__stu__cntl     <= g_cntl;
                pe__stu__type     <= g_type;
                pe__stu__data     <= g_data;
                pe__stu__oob_data <= g_oob;
            end else if (stu__pe__ready) begin
                pe__stu__valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (idle_err) arb__proto_err <= 1'b1;
                    if (found) begin
                        grant      <= win;
                        ptr        <= win_next;
                        first_beat <= 1'b1;
                        state      <= PKT;
                    end
                end
                PKT: begin
                    if (xfer) begin
                        first_beat <= 1'b0;
                        // A second SOP inside an open packet is flagged but still forwarded.
                        if (g_cntl[0] && !first_beat) arb__proto_err <= 1'b1;
                        if (g_cntl[1]) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STACK_UP_ARB_PKT_STATS_EN
    logic [15:0] pkt_cnt [NUM_REQ];

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            for (int i = 0; i < NUM_REQ; i++) pkt_cnt[i] <= 16'd0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (xfer && g_cntl[1] && grant == 3'(i) && pkt_cnt[i] != 16'hFFFF)
                    pkt_cnt[i] <= pkt_cnt[i] + 16'd1;
            end
        end
    end

    always_comb begin
        arb__pkt_count = '0;
        for (int i = 0; i < NUM_REQ; i++) arb__pkt_count[i*16 +: 16] = pkt_cnt[i];
    end
`endif

endmodule

// File: doc/stack_upstream_arbiter.md
Name: stack_upstream_arbiter

Overview:
- Shares the single PE-to-stack-bus upstream port (pe__stu__*) between several upstream sources, e.g. the SIMD upstream interface and DMA/memory-access return paths.
- Arbitration is round-robin and packet-atomic: a grant is held from SOP to EOP, so packets never interleave.
- The arbiter has one registered output stage that drives the stack upstream bus directly.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
CNTL_W, 2, width of cntl field (SOP/EOP encoding)
TYPE_W, 2, width of type field
DATA_W, 64, width of data field
OOB_W, 32, width of oob_data field

Ports:
clk  input  1  clock
reset_poweron  input  1  reset, active-low
req__arb__valid  input  NUM_REQ  per-requester beat valid
req__arb__cntl  input  NUM_REQ*CNTL_W  per-requester cntl; requester i occupies slice [i*CNTL_W +: CNTL_W]
req__arb__type  input  NUM_REQ*TYPE_W  per-requester type (control/data, vector/scalar)
req__arb__data  input  NUM_REQ*DATA_W  per-requester data
req__arb__oob_data  input  NUM_REQ*OOB_W  per-requester OOB data
arb__req__ready  output  NUM_REQ  per-requester ready
pe__stu__valid  output  1  upstream beat valid
pe__stu__cntl  output  CNTL_W  upstream cntl
stu__pe__ready  input  1  upstream ready
pe__stu__type  output  TYPE_W  upstream type
pe__stu__data  output  DATA_W  upstream data
pe__stu__oob_data  output  OOB_W  upstream OOB data
arb__grant_id  output  3  index of current owner (valid when arb__busy)
arb__busy  output  1  high in state PKT
arb__proto_err  output  1  sticky protocol-error flag

Behaviour:
- Clock and reset: one clock, clk. reset_poweron is asynchronous, active-low.
- Reset values: every output is 0; state IDLE; round-robin pointer 0; output register empty.
- cntl encoding:
  - 2'b01 SOP
  - 2'b10 EOP
  - 2'b11 SOP+EOP (single-beat packet)
  - 2'b00 MOP (middle of packet)
- Handshake: valid/ready. A beat transfers on a cycle where valid and ready are both high. Valid must not depend on ready.
- Output stage is a single register:
  - load_ok = ~pe__stu__valid | stu__pe__ready.
  - A beat accepted at cycle t appears on pe__stu__* at t+1.
  - While stu__pe__ready is low, the output holds its value stable.
- FSM state IDLE:
  - All arb__req__ready = 0.
  - Candidates are requesters with valid=1 and cntl[0]=1 (SOP).
  - The winner is the first candidate at or after the pointer, searching in modulo-NUM_REQ order.
  - On a winner: register grant_id, set pointer = winner+1 (wrapping to 0 past NUM_REQ-1), go to PKT.
  - With no candidate, stay in IDLE.
- FSM state PKT:
  - arb__req__ready[grant_id] = load_ok; all other readies = 0.
  - A granted beat with cntl[1]=1 (EOP) returns the FSM to IDLE in the next cycle.
- First-beat latency: request at t, grant at t+1, beat accepted at t+1, beat on pe__stu__* at t+2 (when unstalled).
- Throughput: one bubble cycle per packet (the IDLE arbitration cycle). Back-to-back MOP beats stream at one per cycle.
- Protocol errors set arb__proto_err (sticky; cleared only by reset):
  - A valid beat without SOP on any requester while in IDLE. That beat is not accepted, its ready stays 0, and it remains pending.
  - SOP on a granted beat in PKT that is not the packet's first beat. The beat is passed through unchanged.
- Simultaneous events:
  - EOP accepted in the same cycle a new SOP is pending: the new SOP is arbitrated in the following IDLE cycle.
  - Output register unloads and loads in the same cycle: allowed.
- Reset asserted mid-packet: the packet is aborted. The output register is cleared, so no partial EOP is emitted. The FSM returns to IDLE and the pointer to 0.

Optional Feature:
- Macro: STACK_UP_ARB_PKT_STATS_EN.
- Defined:
  - Adds output port arb__pkt_count, width NUM_REQ*16.
  - Holds one 16-bit saturating counter per requester, incremented on each accepted EOP beat of that requester.
  - Counters saturate at 16'hFFFF and reset to 0.
- Undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Single requester 0 sends a 4-beat packet (SOP, MOP, MOP, EOP; data 1..4) with stu__pe__ready=1 -> pe__stu__ beats 1..4 on consecutive cycles, first at cycle t+2. arb__grant_id=0; arb__busy deasserts after EOP.
- Requesters 0, 1, 2 each hold a 2-beat packet pending from reset -> packets are emitted in order 0, 1, 2, then 0 again if re-requested. Never interleaved, and one idle cycle between packets.
- stu__pe__ready toggles 1,0,0,1 during a 3-beat packet -> pe__stu__data holds stable while ready=0. No beat is lost or duplicated, and arb__req__ready tracks load_ok.
- Requester 1 presents valid with cntl=MOP while in IDLE -> arb__proto_err=1, arb__req__ready[1] stays 0, and no output beat is produced.
- reset_poweron pulsed low mid-packet after beat 2 -> all outputs go to 0 immediately (asynchronously). After release, a new SOP from requester 2 is granted first, since the pointer is 0 and requesters 0 and 1 are idle.
- With STACK_UP_ARB_PKT_STATS_EN defined: send 3 single-beat packets (cntl=SOP+EOP) from requester 1 -> arb__pkt_count slice for requester 1 = 3, other slices = 0.
